// File: rtl/regbank_scan_pkg.sv
// Shared definitions for the register-bank scan front end: bank geometry
// defaults and the scan FSM state encoding.
package regbank_scan_pkg;

    localparam int NREG_DEF = 32;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DUMP_RD  = 3'd1,
        DUMP_TX0 = 3'd2,
        DUMP_TX1 = 3'd3,
        LOAD     = 3'd4
    } state_e;

endpackage

// File: rtl/regbank_scan.sv
// Dump/load front end for the register bank: streams all registers out two per
// bank read, or writes an incoming word stream into registers 0..NREG-1.
module regbank_scan
    import regbank_scan_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dump_start,
    input  logic          load_start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] sr1,
    output logic [AW-1:0] sr2,
    input  logic [DW-1:0] rdData1,
    input  logic [DW-1:0] rdData2,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] wrData,
    output logic          write,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] buf0_q, buf0_d;
    logic [DW-1:0] buf1_q, buf1_d;
    logic          done_q, done_d;

    logic          pair_last;
    logic          load_last;

    assign pair_last = (ptr_q == AW'(NREG - 2));
    assign load_last = (ptr_q == AW'(NREG - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Load has priority; a simultaneous dump request is dropped.
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (dump_start) begin
                    state_d = DUMP_RD;
                    ptr_d   = '0;
                end
            end
            DUMP_RD: begin
                buf0_d  = rdData1;
                buf1_d  = rdData2;
                state_d = DUMP_TX0;
            end
            DUMP_TX0: begin
                if (m_ready) state_d = DUMP_TX1;
            end
            DUMP_TX1: begin
                if (m_ready) begin
                    if (pair_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + AW'(2);
                        state_d = DUMP_RD;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    if (load_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            done_q  <= done_d;
        end
    end

    // Output decode; the load path is a zero-latency pass-through to the bank.
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign sr1     = (state_q == DUMP_RD) ? ptr_q : '0;
    assign sr2     = (state_q == DUMP_RD) ? (ptr_q + AW'(1)) : '0;
    assign m_valid = (state_q == DUMP_TX0) || (state_q == DUMP_TX1);
    assign m_data  = (state_q == DUMP_TX0) ? buf0_q :
                     (state_q == DUMP_TX1) ? buf1_q : '0;
    assign m_last  = (state_q == DUMP_TX1) && pair_last;
    assign s_ready = (state_q == LOAD);
    assign write   = (state_q == LOAD) && s_valid && !reset;
    assign dr      = (state_q == LOAD) ? ptr_q : '0;
    assign wrData  = (state_q == LOAD) ? s_data : '0;

endmodule

// File: tb/tb_regbank_scan.sv
// Directed bench for regbank_scan paired with a behavioural 32 x 32 register bank.
module tb_regbank_scan;
    import regbank_scan_pkg::*;

    localparam int NREG = NREG_DEF;
    localparam int DW   = DW_DEF;
    localparam int AW   = AW_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          dump_start, load_start;
    logic          busy, done;
    logic [AW-1:0] sr1, sr2, dr;
    logic [DW-1:0] rdData1, rdData2, wrData;
    logic          write;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;

    logic [DW-1:0] bank     [NREG];
    logic [DW-1:0] exp_bank [NREG];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_scan #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .dump_start(dump_start), .load_start(load_start),
        .busy(busy), .done(done), .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
        .dr(dr), .wrData(wrData), .write(write), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
    );

    // Register bank: synchronous write, combinational read.
    always_ff @(posedge clk) if (write) bank[dr] <= wrData;
    assign rdData1 = bank[sr1];
    assign rdData2 = bank[sr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic do_load(input logic [31:0] base, input int stall_at, input bit both,
                           input int abort_at);
        int k, cyc, gap;
        bit aborted;
        k = 0; cyc = 0; gap = 0; aborted = 0;
        @(negedge clk);
        load_start = 1'b1; dump_start = both; s_valid = 1'b0;
        while (k < NREG && cyc < 200 && !aborted) begin
            @(negedge clk);
            load_start = 1'b0;
            dump_start = both && (k == 5);
            cyc++;
            if (stall_at == k && gap < 5) begin
                s_valid = 1'b0; gap++;
            end else begin
                s_valid = 1'b1;
            end
            s_data = base + 32'(k);
            if (k == abort_at) reset = 1'b1;
            #2;
            if (cyc == 1) begin
                check("load_busy", 32'(busy), 32'd1);
                check("load_s_ready", 32'(s_ready), 32'd1);
                check("load_m_valid", 32'(m_valid), 32'd0);
            end
            if (reset) begin
                check("load_rst_write", 32'(write), 32'd0);
                aborted = 1'b1;
            end else if (s_valid) begin
                check("load_write", 32'(write), 32'd1);
                check("load_dr", 32'(dr), 32'(k));
                check("load_wrdata", wrData, base + 32'(k));
                exp_bank[k] = base + 32'(k);
                k++;
            end else begin
                check("load_stall_write", 32'(write), 32'd0);
            end
        end
        if (cyc >= 200) check("load_timeout", 32'd0, 32'd1);
        if (aborted) begin
            @(negedge clk);
            reset = 1'b0; s_valid = 1'b0;
            #2;
            check("load_rst_busy", 32'(busy), 32'd0);
            check("load_rst_done", 32'(done), 32'd0);
            check("load_rst_bank", bank[abort_at], exp_bank[abort_at]);
            return;
        end
        check("load_cycles", 32'(cyc), 32'(NREG + ((stall_at >= 0) ? 5 : 0)));
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        check("load_done", 32'(done), 32'd1);
        check("load_done_busy", 32'(busy), 32'd0);
        check("load_done_write", 32'(write), 32'd0);
        for (int i = 0; i < (both ? 3 : 1); i++) begin
            @(negedge clk);
            #2;
            check("load_done_clr", 32'(done), 32'd0);
            check("load_after_busy", 32'(busy), 32'd0);
            check("load_after_mvalid", 32'(m_valid), 32'd0);
        end
    endtask

    // mode 0: ready high; mode 1: 1,0,0,1 per clock; mode 2: 1,0,0,1 per valid cycle.
    task automatic do_dump(input int mode, input int abort_at);
        logic [3:0] pat;
        logic [31:0] held;
        int w, cyc, pi, last_hs;
        bit stalled, aborted;
        pat = 4'b1001;
        w = 0; cyc = 0; pi = 0; last_hs = 0; stalled = 0; aborted = 0; held = '0;
        @(negedge clk);
        dump_start = 1'b1; m_ready = 1'b0;
        while (w < NREG && cyc < 400 && !aborted) begin
            @(negedge clk);
            dump_start = 1'b0;
            cyc++;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[3 - ((cyc - 1) % 4)];
                default: begin
                    m_ready = pat[3 - (pi % 4)];
                    if (m_valid) pi++;
                end
            endcase
            #2;
            if (cyc == 1) begin
                check("dump_rd_busy", 32'(busy), 32'd1);
                check("dump_rd_mvalid", 32'(m_valid), 32'd0);
            end
            if (stalled) begin
                check("dump_hold_valid", 32'(m_valid), 32'd1);
                check("dump_hold_data", m_data, held);
            end
            if (abort_at >= 0 && w == abort_at && m_valid) begin
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                stalled = m_valid && !m_ready;
                held = m_data;
                if (m_valid && m_ready) begin
                    check("dump_data", m_data, exp_bank[w]);
                    check("dump_last", 32'(m_last), 32'(w == NREG - 1));
                    w++;
                    last_hs = cyc;
                end
            end
        end
        if (cyc >= 400) check("dump_timeout", 32'd0, 32'd1);
        if (aborted) begin
            @(negedge clk);
            reset = 1'b0; m_ready = 1'b0;
            #2;
            check("dump_rst_mvalid", 32'(m_valid), 32'd0);
            check("dump_rst_busy", 32'(busy), 32'd0);
            check("dump_rst_last", 32'(m_last), 32'd0);
            check("dump_rst_done", 32'(done), 32'd0);
            @(negedge clk);
            #2;
            check("dump_rst_done2", 32'(done), 32'd0);
            return;
        end
        if (mode == 0) check("dump_last_hs_cycle", 32'(last_hs), 32'd48);
        @(negedge clk);
        m_ready = 1'b0;
        #2;
        check("dump_done", 32'(done), 32'd1);
        check("dump_done_busy", 32'(busy), 32'd0);
        check("dump_done_mvalid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #2;
        check("dump_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; dump_start = 1'b0; load_start = 1'b0;
        m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < NREG; i++) exp_bank[i] = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mdata", m_data, 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_sr1", 32'(sr1), 32'd0);
        check("rst_sr2", 32'(sr2), 32'd0);
        check("rst_dr", 32'(dr), 32'd0);
        reset = 1'b0;

        do_load(32'hA000_0000, -1, 1'b0, -1);
        do_dump(0, -1);
        do_dump(1, -1);
        do_load(32'hC000_0000, 10, 1'b0, -1);
        do_dump(2, -1);
        do_load(32'hB000_0000, -1, 1'b1, -1);
        do_dump(0, 7);
        do_dump(0, -1);
        do_load(32'hD000_0000, -1, 1'b0, 4);
        do_dump(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
